// File: rtl/gm64_mem_pkg.sv
// gm64_mem_pkg
//   Shared definitions for the clkRAM-domain memory arbiter: FSM state
//   encoding, owner codes and the read data returned when the memory
//   controller hangs.
package gm64_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VIC = 1'b1;

    // Returned to the owner when a transaction times out.
    localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the CPU, VIC and memCtrl sides of the memory arbiter.
//
//   Handshake: a requester raises *_req and holds addr/we/wdata stable until
//   it sees *_ack. *_ack is a one-cycle pulse marking completion (rdata is
//   valid in that cycle); the requester drops *_req at the edge where it
//   sees ack. mc_ce is a one-cycle start strobe; mc_busy high then low marks
//   the controller's completion, with mc_rdata valid when mc_busy falls.
//
//   Modports:
//     master - arbiter side (drives acks, rdata, mc_* and status)
//     slave  - requester/controller side
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vic_req;
    logic [ADDR_W-1:0] vic_addr;
    logic              vic_ack;
    logic [DATA_W-1:0] vic_rdata;

    logic              mc_ce;
    logic              mc_write;
    logic [ADDR_W-1:0] mc_addr;
    logic [3:0]        mc_nbytes;
    logic [DATA_W-1:0] mc_wdata;
    logic [DATA_W-1:0] mc_rdata;
    logic              mc_busy;

    logic              timeout_err;
    logic              owner;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vic_req, vic_addr,
               mc_rdata, mc_busy,
        output cpu_ack, cpu_rdata, vic_ack, vic_rdata, mc_ce, mc_write,
               mc_addr, mc_nbytes, mc_wdata, timeout_err, owner
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vic_req, vic_addr,
               mc_rdata, mc_busy,
        input  cpu_ack, cpu_rdata, vic_ack, vic_rdata, mc_ce, mc_write,
               mc_addr, mc_nbytes, mc_wdata, timeout_err, owner
    );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
//   Grant chooser for the memory arbiter. VIC wins by default; the CPU wins
//   when it is the only requester, or when the VIC has already taken
//   MAX_VIC_STREAK consecutive grants while the CPU was waiting.
//
//   Ports:
//     clkRAM, reset      - clock, asynchronous active-low reset
//     cpu_req, vic_req   - raw requests
//     sample             - arbiter is in IDLE and may grant this cycle
//     grant_any          - a grant happens this cycle (combinational)
//     grant_vic          - 1 = VIC is granted, 0 = CPU (combinational)
module mem_arb_grant #(
    parameter int MAX_VIC_STREAK = 4
) (
    input  logic clkRAM,
    input  logic reset,
    input  logic cpu_req,
    input  logic vic_req,
    input  logic sample,
    output logic grant_any,
    output logic grant_vic
);

    localparam int SW = $clog2(MAX_VIC_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VIC_STREAK);

    logic [SW-1:0] vic_streak;
    logic          cpu_starved;

    always_comb begin
        cpu_starved = cpu_req && (vic_streak == STREAK_MAX);
        grant_any   = sample && (cpu_req || vic_req);
        grant_vic   = vic_req && !cpu_starved;
    end

    // Counts VIC grants taken while the CPU was waiting; saturates so the
    // CPU keeps priority until it is actually served.
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            vic_streak <= '0;
        end else if (grant_any) begin
            if (!grant_vic) begin
                vic_streak <= '0;
            end else if (cpu_req && (vic_streak != STREAK_MAX)) begin
                vic_streak <= vic_streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the PSRAM controller between the 6502 CPU and the VIC fetch path.
//   One single-byte transaction at a time: grant in IDLE, strobe mc_ce in
//   ISSUE, wait for mc_busy to rise then fall, return data and pulse the
//   owner's ack. A per-transaction counter aborts a hung controller,
//   returning RD_TIMEOUT_DATA and setting the sticky timeout_err.
//
//   Ports:
//     clkRAM     - RAM clock, all logic on posedge
//     reset      - asynchronous, active-low
//     bus        - CPU / VIC / memCtrl signals (mem_arbiter_if.master)
//     dbg_state  - current FSM state
module mem_arbiter
    import gm64_mem_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int MAX_VIC_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                clkRAM,
    input  logic                reset,
    mem_arbiter_if.master       bus,
    output arb_state_t          dbg_state
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state;
    logic [7:0]        tmo_cnt;
    logic              grant_any;
    logic              grant_vic;

    logic              mc_ce_q;
    logic              mc_write_q;
    logic [ADDR_W-1:0] mc_addr_q;
    logic [DATA_W-1:0] mc_wdata_q;
    logic              cpu_ack_q;
    logic              vic_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vic_rdata_q;
    logic              timeout_err_q;
    logic              owner_q;

    logic              in_wait;
    logic              done_tmo;
    logic              done_ok;
    logic [DATA_W-1:0] done_data;

    mem_arb_grant #(
        .MAX_VIC_STREAK(MAX_VIC_STREAK)
    ) u_grant (
        .clkRAM    (clkRAM),
        .reset     (reset),
        .cpu_req   (bus.cpu_req),
        .vic_req   (bus.vic_req),
        .sample    (state == ST_IDLE),
        .grant_any (grant_any),
        .grant_vic (grant_vic)
    );

    // The timeout check wins over a normal completion in the same cycle.
    always_comb begin
        in_wait   = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
        done_tmo  = in_wait && (tmo_cnt == TMO_LAST);
        done_ok   = (state == ST_WAIT_DONE) && !bus.mc_busy;
        done_data = done_tmo ? DATA_W'(RD_TIMEOUT_DATA) : bus.mc_rdata;
    end

    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            mc_ce_q       <= 1'b0;
            mc_write_q    <= 1'b0;
            mc_addr_q     <= '0;
            mc_wdata_q    <= '0;
            cpu_ack_q     <= 1'b0;
            vic_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            vic_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
            owner_q       <= OWN_CPU;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner_q    <= grant_vic ? OWN_VIC : OWN_CPU;
                        mc_write_q <= grant_vic ? 1'b0 : bus.cpu_we;
                        mc_addr_q  <= grant_vic ? bus.vic_addr : bus.cpu_addr;
                        mc_wdata_q <= grant_vic ? '0 : bus.cpu_wdata;
                        mc_ce_q    <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mc_ce_q <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (done_tmo || done_ok) begin
                        state <= ST_ACK;
                        if (owner_q == OWN_VIC) begin
                            vic_ack_q   <= 1'b1;
                            vic_rdata_q <= done_data;
                        end else begin
                            cpu_ack_q   <= 1'b1;
                            cpu_rdata_q <= done_data;
                        end
                        if (done_tmo) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if ((state == ST_WAIT_BUSY) && bus.mc_busy) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_ACK: begin
                    cpu_ack_q <= 1'b0;
                    vic_ack_q <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mc_ce       = mc_ce_q;
    assign bus.mc_write    = mc_write_q;
    assign bus.mc_addr     = mc_addr_q;
    assign bus.mc_nbytes   = 4'd1;
    assign bus.mc_wdata    = mc_wdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.vic_ack     = vic_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.vic_rdata   = vic_rdata_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.owner       = owner_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small memCtrl model that stays
//   busy for a programmable number of sampled edges after each mc_ce.
module tb_mem_arbiter;
    import gm64_mem_pkg::*;

    logic       clk_ram;
    logic       reset;
    arb_state_t dbg_state;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mem_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (8),
        .MAX_VIC_STREAK (4),
        .TIMEOUT        (255)
    ) dut (
        .clkRAM    (clk_ram),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    // ---------------- memCtrl model ----------------
    int         model_b;
    logic [7:0] model_data;
    int         m_cnt;
    logic       m_busy;
    logic [7:0] m_rdata = 8'h00;

    always @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.mc_ce) begin
            m_cnt  <= model_b;
            m_busy <= (model_b != 0);
            if (!bus.mc_write) m_rdata <= model_data;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_busy <= (m_cnt > 1);
        end
    end

    assign bus.mc_busy  = m_busy;
    assign bus.mc_rdata = m_rdata;

    // ---------------- bus monitor ----------------
    int   n_cpu_ack;
    int   n_vic_ack;
    int   n_ce;
    logic grant_q[$];

    initial begin
        n_cpu_ack = 0;
        n_vic_ack = 0;
        n_ce      = 0;
    end

    always @(posedge clk_ram) begin
        if (bus.cpu_ack) n_cpu_ack <= n_cpu_ack + 1;
        if (bus.vic_ack) n_vic_ack <= n_vic_ack + 1;
        if (bus.mc_ce) begin
            n_ce <= n_ce + 1;
            grant_q.push_back(bus.owner);
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    logic        iss_ce;
    logic        iss_write;
    logic [15:0] iss_addr;
    logic [7:0]  iss_wdata;
    logic        iss_owner;
    logic        post_ce;

    task automatic step();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && dbg_state != ST_IDLE; i++) step();
        chk("wait_idle", dbg_state, ST_IDLE);
    endtask

    // Steps until the requested ack is seen; lat counts edges since the
    // request sample edge.
    task automatic wait_ack(input bit vic, input int max_cyc, inout int lat);
        bit got;
        got = 0;
        while (!got && lat < max_cyc) begin
            if (vic ? bus.vic_ack : bus.cpu_ack) begin
                got = 1;
            end else begin
                step();
                lat++;
                if (lat == 1) post_ce = bus.mc_ce;
            end
        end
        if (!got && (vic ? bus.vic_ack : bus.cpu_ack)) got = 1;
        if (!got) begin
            chk("ack_wait_expired", 32'd0, 32'd1);
            lat = -1;
        end
    endtask

    task automatic txn(input bit vic, input bit we, input logic [15:0] addr,
                       input logic [7:0] wd, output int lat);
        wait_idle();
        if (vic) begin
            bus.vic_req  = 1'b1;
            bus.vic_addr = addr;
        end else begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = we;
            bus.cpu_addr  = addr;
            bus.cpu_wdata = wd;
        end
        step();
        iss_ce    = bus.mc_ce;
        iss_write = bus.mc_write;
        iss_addr  = bus.mc_addr;
        iss_wdata = bus.mc_wdata;
        iss_owner = bus.owner;
        lat = 0;
        wait_ack(vic, 400, lat);
        if (vic) bus.vic_req = 1'b0;
        else     bus.cpu_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int   lat;
    int   base_cpu;
    int   base_vic;
    int   base_ce;
    int   acks;
    logic exp_q[$];

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vic_req   = 1'b0;
        bus.vic_addr  = '0;
        model_b       = 1;
        model_data    = 8'h00;
        post_ce       = 1'b0;

        repeat (3) @(posedge clk_ram);
        #1;
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_mc_ce", bus.mc_ce, 0);
        chk("rst_mc_addr", bus.mc_addr, 0);
        chk("rst_mc_nbytes", bus.mc_nbytes, 1);
        chk("rst_acks", {bus.cpu_ack, bus.vic_ack}, 0);
        chk("rst_rdata", {bus.cpu_rdata, bus.vic_rdata}, 0);
        chk("rst_err_owner", {bus.timeout_err, bus.owner}, 0);
        reset = 1'b1;
        step();

        // CPU write alone, controller busy for 3 sampled edges: ack at 2+3.
        base_cpu = n_cpu_ack; base_vic = n_vic_ack;
        model_b = 3;
        txn(1'b0, 1'b1, 16'hD020, 8'h05, lat);
        chk("wr_issue_ce", iss_ce, 1);
        chk("wr_ce_one_cycle", post_ce, 0);
        chk("wr_mc_addr", iss_addr, 16'hD020);
        chk("wr_mc_write", iss_write, 1);
        chk("wr_mc_wdata", iss_wdata, 8'h05);
        chk("wr_owner", iss_owner, OWN_CPU);
        chk("wr_latency", lat, 5);
        step();
        chk("wr_cpu_ack_once", n_cpu_ack - base_cpu, 1);
        chk("wr_no_vic_ack", n_vic_ack - base_vic, 0);

        // VIC read alone, B=1: ack at 3.
        base_cpu = n_cpu_ack;
        model_b = 1; model_data = 8'h20;
        txn(1'b1, 1'b0, 16'h0400, 8'h00, lat);
        chk("vic_latency", lat, 3);
        chk("vic_rdata", bus.vic_rdata, 8'h20);
        chk("vic_mc_addr", iss_addr, 16'h0400);
        chk("vic_mc_write", iss_write, 0);
        chk("vic_owner", iss_owner, OWN_VIC);
        chk("vic_cpu_rdata_kept", bus.cpu_rdata, 8'h00);
        step();
        chk("vic_no_cpu_ack", n_cpu_ack - base_cpu, 0);

        // Contention: both requests held, expect V,V,V,V,C,V,V,V,V,C.
        wait_idle();
        grant_q.delete();
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        base_cpu = n_cpu_ack; base_vic = n_vic_ack;
        model_b = 1; model_data = 8'h11;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1000;
        bus.vic_req = 1'b1; bus.vic_addr = 16'h2000;
        acks = 0;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            step();
            if (bus.cpu_ack || bus.vic_ack) acks++;
        end
        bus.cpu_req = 1'b0; bus.vic_req = 1'b0;
        repeat (4) step();
        chk("cont_ack_total", acks, 10);
        chk("cont_grant_count", grant_q.size(), 10);
        for (int i = 0; i < 10 && i < grant_q.size(); i++) begin
            chk($sformatf("cont_grant_%0d", i), grant_q[i], exp_q[i]);
        end
        chk("cont_cpu_acks", n_cpu_ack - base_cpu, 2);
        chk("cont_vic_acks", n_vic_ack - base_vic, 8);

        // Dropped request: cpu_req released in WAIT_BUSY.
        wait_idle();
        base_cpu = n_cpu_ack; base_ce = n_ce;
        model_b = 3; model_data = 8'hC3;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
        step();
        step();
        chk("drop_in_wait_busy", dbg_state, ST_WAIT_BUSY);
        bus.cpu_req = 1'b0;
        lat = 1;
        wait_ack(1'b0, 40, lat);
        chk("drop_latency", lat, 5);
        chk("drop_rdata", bus.cpu_rdata, 8'hC3);
        repeat (6) step();
        chk("drop_one_ce", n_ce - base_ce, 1);
        chk("drop_one_ack", n_cpu_ack - base_cpu, 1);
        chk("drop_back_idle", dbg_state, ST_IDLE);

        // Timeout: controller never busy. Counter runs from the first wait
        // edge (E2) and hits TIMEOUT-1 at E256, so ack is at 1+TIMEOUT.
        model_b = 0;
        chk("tmo_err_before", bus.timeout_err, 0);
        txn(1'b0, 1'b0, 16'h8000, 8'h00, lat);
        chk("tmo_latency", lat, 256);
        chk("tmo_rdata", bus.cpu_rdata, 8'hFF);
        chk("tmo_err_set", bus.timeout_err, 1);
        step();

        // Good transaction afterwards keeps timeout_err.
        model_b = 2; model_data = 8'h3C;
        txn(1'b0, 1'b0, 16'h8001, 8'h00, lat);
        chk("post_tmo_latency", lat, 4);
        chk("post_tmo_rdata", bus.cpu_rdata, 8'h3C);
        chk("post_tmo_err_sticky", bus.timeout_err, 1);

        // Reset in WAIT_DONE.
        wait_idle();
        base_cpu = n_cpu_ack; base_vic = n_vic_ack;
        model_b = 5; model_data = 8'h99;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'hABCD; bus.cpu_wdata = 8'h5A;
        step();
        step();
        step();
        chk("rmid_in_wait_done", dbg_state, ST_WAIT_DONE);
        #2;
        reset = 1'b0;
        #1;
        chk("rmid_state", dbg_state, ST_IDLE);
        chk("rmid_mc", {bus.mc_ce, bus.mc_write}, 0);
        chk("rmid_mc_addr", bus.mc_addr, 0);
        chk("rmid_mc_wdata", bus.mc_wdata, 0);
        chk("rmid_rdata", {bus.cpu_rdata, bus.vic_rdata}, 0);
        chk("rmid_err_owner", {bus.timeout_err, bus.owner}, 0);
        bus.cpu_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (8) step();
        chk("rmid_no_ack", (n_cpu_ack - base_cpu) + (n_vic_ack - base_vic), 0);

        // Fresh request after reset.
        model_b = 1; model_data = 8'h77;
        txn(1'b1, 1'b0, 16'h0C00, 8'h00, lat);
        chk("fresh_latency", lat, 3);
        chk("fresh_rdata", bus.vic_rdata, 8'h77);
        chk("fresh_err_clear", bus.timeout_err, 0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time bound expired");
    end

endmodule
